kernel_frame_ctrl: RTL and testbench

//  Sequencer and configuration controller for the kernel row-buffer stage. It monitors the
//  dvi/dtypei stream entering the kernel and tracks the frame/row/pixel structure.

---
 rtl/kernel_frame_ctrl_if.sv | 24 ++
 rtl/kernel_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_kernel_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_frame_ctrl_if.sv
// rtl/kernel_frame_ctrl_if.sv - stream beat and kernel-enable request bundle for kernel_frame_ctrl
// Also holds the beat-type encoding shared by the controller and anything driving the stream.
`ifndef KFC_DTYPE_DEFS
`define KFC_DTYPE_DEFS
`define DTYPE_WIDTH        4
`define DTYPE_PIXEL_MASK   4'h8
`define DTYPE_HEADER_START 4'h1
`define DTYPE_HEADER       4'h2
`define DTYPE_FRAME_START  4'h3
`define DTYPE_ROW_START    4'h4
`define DTYPE_ROW_END      4'h5
`define DTYPE_FRAME_END    4'h6
`endif

interface kernel_frame_ctrl_if;
  logic                    dvi;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic                    cfg_valid;
  logic                    cfg_enable;
  logic                    cfg_ack;

  modport master (output dvi, output dtypei, output cfg_valid, output cfg_enable, input cfg_ack);
  modport slave  (input dvi, input dtypei, input cfg_valid, input cfg_enable, output cfg_ack);
endinterface

// File: rtl/kernel_frame_ctrl.sv
// rtl/kernel_frame_ctrl.sv - frame/row sequencer, geometry monitor and boundary-synchronised kernel enable
// Every output is registered and reflects the beat seen on the previous clock.
module kernel_frame_ctrl #(
  parameter int NUM_COLS_WIDTH  = 11,
  parameter int NUM_ROWS_WIDTH  = 11,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetb,
  kernel_frame_ctrl_if.slave         strm,
  input  logic                       err_clr,
  output logic                       kernel_enable,
  output logic                       frame_active,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [NUM_ROWS_WIDTH-1:0]  last_num_rows,
  output logic [NUM_COLS_WIDTH-1:0]  last_num_cols,
  output logic                       err_seq,
  output logic                       err_row_len
);

  typedef enum logic [1:0] {IDLE, HEADER, FRAME, ROW} state_t;

  state_t                    state, state_nxt;
  logic [NUM_COLS_WIDTH-1:0] col_cnt, ref_cols;
  logic [NUM_ROWS_WIDTH-1:0] row_cnt;
  logic                      first_row;
  logic                      pend_valid, pend_value;

  logic b_pix, b_hs, b_hdr, b_fs, b_rs, b_re, b_fe;
  logic seq_set, row_set, start_row, end_row, end_frame, add_pix, apply;

  assign b_pix = strm.dvi && (|(strm.dtypei & `DTYPE_PIXEL_MASK));
  assign b_hs  = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_HEADER_START);
  assign b_hdr = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_HEADER);
  assign b_fs  = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_FRAME_START);
  assign b_rs  = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_ROW_START);
  assign b_re  = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_ROW_END);
  assign b_fe  = strm.dvi && !b_pix && (strm.dtypei == `DTYPE_FRAME_END);

  // Enable changes only land on a frame-opening beat seen while idle.
  assign apply   = (b_hs || b_fs) && (state == IDLE);
  assign row_set = end_row && !first_row && (col_cnt != ref_cols);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seq_set   = 1'b0;
    start_row = 1'b0;
    end_row   = 1'b0;
    end_frame = 1'b0;
    add_pix   = 1'b0;
    if (b_fs) begin
      state_nxt = FRAME;
      seq_set   = (state == FRAME) || (state == ROW);
    end else if (strm.dvi) begin
      case (state)
        IDLE: begin
          if (b_hs) state_nxt = HEADER;
          else if (b_hdr || b_pix || b_rs || b_re || b_fe) seq_set = 1'b1;
        end
        HEADER: begin
          if (!b_hdr) seq_set = 1'b1;
        end
        FRAME: begin
          if (b_rs) begin
            state_nxt = ROW;
            start_row = 1'b1;
          end else if (b_fe) begin
            state_nxt = IDLE;
            end_frame = 1'b1;
          end else begin
            seq_set = 1'b1;
          end
        end
        ROW: begin
          if (b_pix) begin
            add_pix = 1'b1;
          end else if (b_re) begin
            state_nxt = FRAME;
            end_row   = 1'b1;
          end else begin
            seq_set = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      col_cnt       <= '0;
      ref_cols      <= '0;
      row_cnt       <= '0;
      first_row     <= 1'b0;
      pend_valid    <= 1'b0;
      pend_value    <= 1'b0;
      kernel_enable <= 1'b0;
      frame_active  <= 1'b0;
      frame_count   <= '0;
      last_num_rows <= '0;
      last_num_cols <= '0;
      err_seq       <= 1'b0;
      err_row_len   <= 1'b0;
      strm.cfg_ack  <= 1'b0;
    end else begin
      if (b_fs) begin
        row_cnt   <= '0;
        first_row <= 1'b1;
      end else if (end_row) begin
        if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
        if (first_row) ref_cols <= col_cnt;
        first_row <= 1'b0;
      end

      if (start_row)                    col_cnt <= '0;
      else if (add_pix && col_cnt != '1) col_cnt <= col_cnt + 1'b1;

      if (end_frame) begin
        last_num_rows <= row_cnt;
        last_num_cols <= ref_cols;
        frame_count   <= frame_count + 1'b1;
      end

      if (b_fs)           frame_active <= 1'b1;
      else if (end_frame) frame_active <= 1'b0;

      // A new error on the clear cycle must survive the clear.
      err_seq     <= seq_set | (err_seq & ~err_clr);
      err_row_len <= row_set | (err_row_len & ~err_clr);

      strm.cfg_ack <= 1'b0;
      if (apply && (strm.cfg_valid || pend_valid)) begin
        kernel_enable <= strm.cfg_valid ? strm.cfg_enable : pend_value;
        pend_valid    <= 1'b0;
        strm.cfg_ack  <= 1'b1;
      end else if (strm.cfg_valid) begin
        pend_valid <= 1'b1;
        pend_value <= strm.cfg_enable;
      end
    end
  end

endmodule

// File: tb/tb_kernel_frame_ctrl.sv
// tb/tb_kernel_frame_ctrl.sv - directed and randomized bench for kernel_frame_ctrl
// Expected outputs come from a beat-level model that tracks rows as a list of lengths.
`ifndef KFC_DTYPE_DEFS
`define KFC_DTYPE_DEFS
`define DTYPE_WIDTH        4
`define DTYPE_PIXEL_MASK   4'h8
`define DTYPE_HEADER_START 4'h1
`define DTYPE_HEADER       4'h2
`define DTYPE_FRAME_START  4'h3
`define DTYPE_ROW_START    4'h4
`define DTYPE_ROW_END      4'h5
`define DTYPE_FRAME_END    4'h6
`endif

module tb_kernel_frame_ctrl;
  localparam logic [3:0] HS  = `DTYPE_HEADER_START;
  localparam logic [3:0] HDR = `DTYPE_HEADER;
  localparam logic [3:0] FS  = `DTYPE_FRAME_START;
  localparam logic [3:0] RS  = `DTYPE_ROW_START;
  localparam logic [3:0] RE  = `DTYPE_ROW_END;
  localparam logic [3:0] FE  = `DTYPE_FRAME_END;
  localparam logic [3:0] PX  = 4'h8;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        err_clr = 1'b0;
  logic        kernel_enable, frame_active, err_seq, err_row_len;
  logic [15:0] frame_count;
  logic [10:0] last_num_rows, last_num_cols;

  kernel_frame_ctrl_if bus ();

  kernel_frame_ctrl dut (
    .clk(clk), .resetb(resetb), .strm(bus.slave), .err_clr(err_clr),
    .kernel_enable(kernel_enable), .frame_active(frame_active), .frame_count(frame_count),
    .last_num_rows(last_num_rows), .last_num_cols(last_num_cols),
    .err_seq(err_seq), .err_row_len(err_row_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int step_no = 0;
  int ack_seen = 0;

  // Reference model: where we are in the frame, plus the lengths of rows closed so far.
  bit m_hdr, m_frm, m_row;
  int m_row_lens[$];
  int m_cols, m_ref, m_cnt, m_lrows, m_lcols;
  bit m_ken, m_ack, m_act, m_eseq, m_erow, m_pend, m_pval;

  task automatic model_reset();
    m_hdr = 0; m_frm = 0; m_row = 0; m_row_lens.delete();
    m_cols = 0; m_ref = 0; m_cnt = 0; m_lrows = 0; m_lcols = 0;
    m_ken = 0; m_ack = 0; m_act = 0; m_eseq = 0; m_erow = 0; m_pend = 0; m_pval = 0;
  endtask

  task automatic model(input bit v, input logic [3:0] t, input bit cv, input bit ce, input bit clr);
    bit idle, pix, sset, rset;
    idle = !(m_hdr || m_frm || m_row);
    pix  = v && t[3];
    sset = 0;
    rset = 0;
    m_ack = 0;
    if (v && idle && (t == HS || t == FS) && (cv || m_pend)) begin
      m_ken = cv ? ce : m_pval;
      m_pend = 0;
      m_ack = 1;
    end else if (cv) begin
      m_pend = 1;
      m_pval = ce;
    end
    if (v) begin
      if (t == FS) begin
        sset = m_frm || m_row;
        m_hdr = 0; m_frm = 1; m_row = 0;
        m_row_lens.delete();
        m_act = 1;
      end else if (pix) begin
        if (m_row) m_cols = (m_cols < 2047) ? m_cols + 1 : 2047;
        else sset = 1;
      end else if (t == HS) begin
        if (idle) m_hdr = 1; else sset = 1;
      end else if (t == HDR) begin
        if (!m_hdr) sset = 1;
      end else if (t == RS) begin
        if (m_frm) begin m_frm = 0; m_row = 1; m_cols = 0; end
        else sset = 1;
      end else if (t == RE) begin
        if (m_row) begin
          if (m_row_lens.size() == 0) m_ref = m_cols;
          else if (m_cols != m_ref) rset = 1;
          m_row_lens.push_back(m_cols);
          m_row = 0; m_frm = 1;
        end else sset = 1;
      end else if (t == FE) begin
        if (m_frm) begin
          m_frm = 0;
          m_lrows = (m_row_lens.size() < 2047) ? m_row_lens.size() : 2047;
          m_lcols = m_ref;
          m_cnt = (m_cnt + 1) % 65536;
          m_act = 0;
        end else sset = 1;
      end
    end
    m_eseq = sset ? 1'b1 : (clr ? 1'b0 : m_eseq);
    m_erow = rset ? 1'b1 : (clr ? 1'b0 : m_erow);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("kernel_enable", 32'(kernel_enable), 32'(m_ken));
    check("cfg_ack", 32'(bus.cfg_ack), 32'(m_ack));
    check("frame_active", 32'(frame_active), 32'(m_act));
    check("frame_count", 32'(frame_count), 32'(m_cnt));
    check("last_num_rows", 32'(last_num_rows), 32'(m_lrows));
    check("last_num_cols", 32'(last_num_cols), 32'(m_lcols));
    check("err_seq", 32'(err_seq), 32'(m_eseq));
    check("err_row_len", 32'(err_row_len), 32'(m_erow));
  endtask

  task automatic step(input bit v, input logic [3:0] t, input bit cv = 0, input bit ce = 0,
                      input bit clr = 0);
    @(negedge clk);
    bus.dvi = v; bus.dtypei = t; bus.cfg_valid = cv; bus.cfg_enable = ce; err_clr = clr;
    @(posedge clk);
    #1;
    step_no++;
    model(v, t, cv, ce, clr);
    if (bus.cfg_ack === 1'b1) ack_seen++;
    compare_all();
  endtask

  task automatic row(input int n);
    step(1, RS);
    for (int i = 0; i < n; i++) step(1, PX);
    step(1, RE);
  endtask

  task automatic rstep(input logic [3:0] t);
    bit cv, ce, clr;
    cv  = ($urandom_range(0, 7) == 0);
    ce  = $urandom_range(0, 1);
    clr = ($urandom_range(0, 15) == 0);
    step(1, t, cv, ce, clr);
  endtask

  task automatic rpix();
    rstep(4'($urandom_range(8, 15)));
  endtask

  initial begin
    bus.dvi = 0; bus.dtypei = '0; bus.cfg_valid = 0; bus.cfg_enable = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk); @(negedge clk);
    resetb = 1'b1;
    step(0, '0);

    // Header of four beats, three 5-pixel rows.
    step(1, HS); step(1, HDR); step(1, HDR); step(1, HDR);
    step(1, FS);
    for (int r = 0; r < 3; r++) row(5);
    step(1, FE);
    check("t1_rows", 32'(last_num_rows), 32'd3);
    check("t1_cols", 32'(last_num_cols), 32'd5);
    check("t1_count", 32'(frame_count), 32'd1);
    check("t1_errs", 32'({err_seq, err_row_len}), 32'd0);

    // Enable requested mid-row waits for the next frame boundary.
    step(1, HS); step(1, FS); step(1, RS); step(1, PX);
    step(1, PX, 1, 1);
    step(1, PX); step(1, RE); step(1, FE);
    check("t2_hold", 32'(kernel_enable), 32'd0);
    ack_seen = 0;
    step(1, HS);
    check("t2_enable", 32'(kernel_enable), 32'd1);
    check("t2_ack", 32'(bus.cfg_ack), 32'd1);
    step(1, FS);
    check("t2_ack_once", 32'(bus.cfg_ack), 32'd0);

    // Two requests before the boundary: the later one wins with a single ack.
    step(1, RS); step(1, PX, 1, 1); step(1, PX, 1, 0); step(1, RE); step(1, FE);
    ack_seen = 0;
    step(1, FS); step(0, '0); step(0, '0);
    check("t3_acks", 32'(ack_seen), 32'd1);
    check("t3_enable", 32'(kernel_enable), 32'd0);

    // Ragged third row.
    row(5); row(5);
    check("t4_clean", 32'(err_row_len), 32'd0);
    row(4);
    check("t4_ragged", 32'(err_row_len), 32'd1);
    step(0, '0, 0, 0, 1);
    check("t4_clear", 32'(err_row_len), 32'd0);
    step(1, FE);

    // Pixel outside a row, then a frame restart inside a row.
    step(1, FS); step(1, PX);
    check("t5_pix_seq", 32'(err_seq), 32'd1);
    step(0, '0, 0, 0, 1);
    step(1, RS); step(1, PX); step(1, FS);
    check("t5_fs_seq", 32'(err_seq), 32'd1);
    row(2);
    step(1, FE);
    check("t5_restart_rows", 32'(last_num_rows), 32'd1);
    step(0, '0, 0, 0, 1);

    // Reset in the middle of a row with a request pending.
    step(1, HS); step(1, FS); step(1, RS); step(1, PX, 1, 1); step(1, PX);
    @(negedge clk);
    bus.dvi = 0; bus.cfg_valid = 0; err_clr = 0;
    resetb = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    resetb = 1'b1;
    ack_seen = 0;
    step(1, HS); step(1, FS); step(0, '0);
    check("t6_no_ack", 32'(ack_seen), 32'd0);
    check("t6_enable", 32'(kernel_enable), 32'd0);
    step(1, FE);

    // Randomized frames with ragged rows, stray beats, requests and clears.
    for (int f = 0; f < 40; f++) begin
      int gaps, nrows, base, len;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) step(0, '0, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      if ($urandom_range(0, 1)) begin
        rstep(HS);
        for (int h = $urandom_range(0, 3); h > 0; h--) rstep(HDR);
      end
      rstep(FS);
      nrows = $urandom_range(0, 4);
      base  = $urandom_range(0, 6);
      for (int r = 0; r < nrows; r++) begin
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : base;
        rstep(RS);
        for (int p = 0; p < len; p++) rpix();
        if ($urandom_range(0, 19) == 0) begin
          case ($urandom_range(0, 4))
            0: rstep(HS);
            1: rstep(HDR);
            2: rstep(RS);
            3: rstep(FE);
            default: rstep(FS);
          endcase
        end
        rstep(RE);
      end
      if ($urandom_range(0, 19) == 0) rpix();
      rstep(FE);
    end
    step(0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
